cache_clock_nway: RTL

- Fully associative N-way line cache with CLOCK (second-chance) replacement.
- Generalised successor of the 2-way line cache: parametrised way count, per-way valid bits, synchronous reset, and an explicit busy/done handshake for multi-cycle eviction.
- Sits between a requester and backing store. It holds whole lines keyed by full address and has no backing-store port; misses only install.

---
 rtl/cache_clock_nway.sv | 105 ++++++++++
 1 files changed

// File: rtl/cache_clock_nway.sv
// Fully associative N-way line cache with CLOCK (second-chance) replacement.
// Write misses sweep the hand one way per cycle until a victim is installed.
module cache_clock_nway #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int WAYS       = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LINE_WIDTH-1:0] in_val,
  input  logic                  read,
  input  logic                  write,
  output logic                  busy,
  output logic                  hit,
  output logic                  done,
  output logic [LINE_WIDTH-1:0] out_val
);
  localparam int HW = $clog2(WAYS);

  typedef enum logic {IDLE, EVICT} state_t;

  state_t                             state_q;
  logic [WAYS-1:0]                    valid_q, ref_q;
  logic [WAYS-1:0][ADDR_WIDTH-1:0]    addr_q;
  logic [WAYS-1:0][LINE_WIDTH-1:0]    val_q;
  logic [HW-1:0]                      hand_q;
  logic [ADDR_WIDTH-1:0]              pend_addr_q;
  logic [LINE_WIDTH-1:0]              pend_val_q;
  logic                               busy_q, hit_q, done_q;
  logic [LINE_WIDTH-1:0]              out_q;

  logic [WAYS-1:0] match_vec;
  logic [HW-1:0]   match_idx;
  logic            match_any;

  for (genvar g = 0; g < WAYS; g++) begin : g_match
    assign match_vec[g] = valid_q[g] && (addr_q[g] == in_addr);
  end

  // Installs only happen on a miss, so match_vec is one-hot or zero.
  always_comb begin
    match_idx = '0;
    for (int i = 0; i < WAYS; i++)
      if (match_vec[i]) match_idx = HW'(i);
  end
  assign match_any = |match_vec;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      ref_q   <= '0;
      hand_q  <= '0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      hit_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (write) begin
            if (match_any) begin
              val_q[match_idx] <= in_val;
              ref_q[match_idx] <= 1'b1;
              hit_q            <= 1'b1;
              done_q           <= 1'b1;
            end else begin
              pend_addr_q <= in_addr;
              pend_val_q  <= in_val;
              busy_q      <= 1'b1;
              state_q     <= EVICT;
            end
          end else if (read) begin
            hit_q <= match_any;
            out_q <= match_any ? val_q[match_idx] : '0;
            if (match_any) ref_q[match_idx] <= 1'b1;
          end
        end
        EVICT: begin
          hand_q <= hand_q + HW'(1);
          if (!valid_q[hand_q] || !ref_q[hand_q]) begin
            valid_q[hand_q] <= 1'b1;
            ref_q[hand_q]   <= 1'b1;
            addr_q[hand_q]  <= pend_addr_q;
            val_q[hand_q]   <= pend_val_q;
            busy_q          <= 1'b0;
            done_q          <= 1'b1;
            state_q         <= IDLE;
          end else begin
            ref_q[hand_q] <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign hit     = hit_q;
  assign done    = done_q;
  assign out_val = out_q;
endmodule
